// File: rtl/vcve2_vlsu_pkg.sv
// Shared definitions for the vector load/store sequencer.
//   seq_state_e       : sequencer FSM state encoding
//   DefVlenWords      : default maximum element count per vector memory op
//   DefMaxOutstanding : default limit on granted-but-unanswered requests
//   FullWordBe        : byte enable for a full 32-bit word access
package vcve2_vlsu_pkg;

    localparam int unsigned DefVlenWords      = 8;
    localparam int unsigned DefMaxOutstanding = 2;
    localparam logic [3:0]  FullWordBe        = 4'b1111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/vcve2_outstanding_cnt.sv
// Up/down counter of granted-but-unanswered memory requests.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   inc_i         : a request was granted this cycle
//   dec_i         : a response arrived this cycle
//   count_o       : current number of outstanding requests
//   full_o        : count has reached MaxCount
//   empty_o       : count is zero
// Simultaneous inc and dec leave the count unchanged. The caller must not
// increment when full or decrement when empty.
module vcve2_outstanding_cnt
    import vcve2_vlsu_pkg::*;
#(
    parameter int unsigned MaxCount = DefMaxOutstanding,
    parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + CntW'(1);
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(MaxCount));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vcve2_vlsu_sequencer.sv
// Vector load/store sequencer: turns one start pulse into a strided sequence
// of word requests on the data memory port and moves data to/from the VRF.
//   start_i, we_i, base_addr_i, stride_i, vl_i : op command, sampled on start
//   busy_o, done_o, err_o                      : op status
//   vrf_rd_idx_o / vrf_rd_data_i               : store data read from the VRF
//   vrf_wr_en_o / vrf_wr_idx_o / vrf_wr_data_o : load writeback to the VRF
//   data_*                                     : memory request/response port
module vcve2_vlsu_sequencer
    import vcve2_vlsu_pkg::*;
#(
    parameter int unsigned VlenWords      = DefVlenWords,
    parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         we_i,
    input  logic [31:0]                  base_addr_i,
    input  logic [31:0]                  stride_i,
    input  logic [$clog2(VlenWords):0]   vl_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(VlenWords)-1:0] vrf_rd_idx_o,
    input  logic [31:0]                  vrf_rd_data_i,
    output logic                         vrf_wr_en_o,
    output logic [$clog2(VlenWords)-1:0] vrf_wr_idx_o,
    output logic [31:0]                  vrf_wr_data_o,
    output logic                         data_req_o,
    input  logic                         data_gnt_i,
    input  logic                         data_rvalid_i,
    output logic                         data_we_o,
    output logic [3:0]                   data_be_o,
    output logic [31:0]                  data_addr_o,
    output logic [31:0]                  data_wdata_o,
    input  logic [31:0]                  data_rdata_i,
    input  logic                         data_err_i
);

    localparam int unsigned IdxW = $clog2(VlenWords);
    localparam int unsigned VlW  = IdxW + 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    seq_state_e      state_q;
    logic            we_q;
    logic            err_q;
    logic [31:0]     addr_q;
    logic [31:0]     stride_q;
    logic [VlW-1:0]  vl_q;
    logic [IdxW-1:0] issue_idx_q;
    logic [IdxW-1:0] resp_idx_q;

    logic [CntW-1:0] cnt_count;
    logic            cnt_full;
    logic            cnt_empty;
    logic            gnt_fire;
    logic            rsp_fire;
    logic            last_issue;
    logic            drain_done;

    assign gnt_fire   = data_req_o && data_gnt_i;
    // Responses are only meaningful while something is outstanding; this also
    // drops stray rvalids seen in IDLE or after a mid-op reset.
    assign rsp_fire   = data_rvalid_i && (state_q != StIdle) && !cnt_empty;
    assign last_issue = ({1'b0, issue_idx_q} == (vl_q - VlW'(1)));
    // DRAIN is always entered with at least one request outstanding.
    assign drain_done = cnt_empty || ((cnt_count == CntW'(1)) && rsp_fire);

    vcve2_outstanding_cnt #(
        .MaxCount (MaxOutstanding),
        .CntW     (CntW)
    ) u_outstanding_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (gnt_fire),
        .dec_i   (rsp_fire),
        .count_o (cnt_count),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            stride_q    <= '0;
            vl_q        <= '0;
            issue_idx_q <= '0;
            resp_idx_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        we_q        <= we_i;
                        err_q       <= 1'b0;
                        addr_q      <= base_addr_i;
                        stride_q    <= stride_i;
                        vl_q        <= vl_i;
                        issue_idx_q <= '0;
                        resp_idx_q  <= '0;
                        state_q     <= (vl_i == '0) ? StDone : StIssue;
                    end
                end
                StIssue: begin
                    if (gnt_fire) begin
                        // Accumulate instead of multiplying index by stride.
                        addr_q      <= addr_q + stride_q;
                        issue_idx_q <= issue_idx_q + IdxW'(1);
                        if (last_issue) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (rsp_fire) begin
                resp_idx_q <= resp_idx_q + IdxW'(1);
                if (data_err_i) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign err_o         = err_q;

    assign data_req_o    = (state_q == StIssue) && !cnt_full;
    assign data_we_o     = we_q;
    assign data_be_o     = FullWordBe;
    assign data_addr_o   = addr_q;
    assign data_wdata_o  = ((state_q == StIssue) && we_q) ? vrf_rd_data_i : '0;

    assign vrf_rd_idx_o  = issue_idx_q;
    assign vrf_wr_en_o   = rsp_fire && !we_q && !data_err_i;
    assign vrf_wr_idx_o  = resp_idx_q;
    assign vrf_wr_data_o = data_rdata_i;

endmodule

// File: doc/vcve2_vlsu_sequencer.md
VCVE2_VLSU_SEQUENCER -- requirements
Module: vcve2_vlsu_sequencer

Interface
REQ-001 SHALL have parameter VlenWords, default 8, max elements per vector memory op.
REQ-002 SHALL have parameter MaxOutstanding, default 2, max granted-but-unanswered requests.
REQ-003 SHALL have clk_i  in  1  sole clock, rising edge.
REQ-004 SHALL have rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have start_i  in  1  single-cycle op start pulse.
REQ-006 SHALL have we_i  in  1  op is store (1) or load (0), sampled at start.
REQ-007 SHALL have base_addr_i  in  32  element-0 byte address, word aligned, sampled at start.
REQ-008 SHALL have stride_i  in  32  byte stride between elements, two's complement, word multiple, sampled at start.
REQ-009 SHALL have vl_i  in  $clog2(VlenWords)+1  element count 0..VlenWords, sampled at start.
REQ-010 SHALL have busy_o  out  1  op in progress; done_o  out  1  one-cycle completion pulse; err_o  out  1  op saw data_err_i.
REQ-011 SHALL have vrf_rd_idx_o  out  $clog2(VlenWords)  store element index; vrf_rd_data_i  in  32  combinational read data for that index.
REQ-012 SHALL have vrf_wr_en_o  out  1; vrf_wr_idx_o  out  $clog2(VlenWords); vrf_wr_data_o  out  32  load writeback.
REQ-013 SHALL have data_req_o out 1, data_gnt_i in 1, data_rvalid_i in 1, data_we_o out 1, data_be_o out 4, data_addr_o out 32, data_wdata_o out 32, data_rdata_i in 32, data_err_i in 1: VRF-side port of the data memory arbiter.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: start_i with vl_i>0 -> ISSUE; start_i with vl_i=0 -> DONE, no memory request; start_i while not IDLE SHALL be ignored.
REQ-016 ISSUE: data_req_o=1 while outstanding<MaxOutstanding; address/we/wdata SHALL stay stable until data_gnt_i.
REQ-017 Element i address SHALL be base + i*stride, modulo 2^32 (wrap-around silent); data_be_o SHALL be 4'b1111.
REQ-018 Issue index SHALL advance on each data_req_o&&data_gnt_i; after grant of element vl-1 -> DRAIN (same-cycle grant and state change).
REQ-019 Outstanding counter SHALL +1 on grant, -1 on data_rvalid_i, unchanged when both occur in the same cycle.
REQ-020 Store: vrf_rd_idx_o SHALL equal issue index; data_wdata_o SHALL equal vrf_rd_data_i.
REQ-021 Load: each data_rvalid_i SHALL assert vrf_wr_en_o same cycle, vrf_wr_idx_o = response index, vrf_wr_data_o = data_rdata_i; response index +1 per rvalid; responses in order.
REQ-022 Store responses SHALL only decrement the counter; vrf_wr_en_o=0 throughout a store.
REQ-023 data_err_i with data_rvalid_i SHALL set err_o; err_o sticky until next accepted start; an errored load SHALL not write the VRF; issuing SHALL continue.
REQ-024 DRAIN: when outstanding reaches 0 (including via same-cycle rvalid) -> DONE.
REQ-025 DONE: done_o=1 for exactly one cycle, then IDLE; busy_o=1 in ISSUE, DRAIN and DONE.
REQ-026 data_rvalid_i in IDLE SHALL be ignored (no write, no counter underflow).

Reset
REQ-027 rst_ni low at a clock edge SHALL force IDLE, counters/indices 0, err_o=0, done_o=0, busy_o=0, data_req_o=0, vrf_wr_en_o=0, mid-operation included.
REQ-028 After reset, data_addr_o, data_wdata_o, vrf_rd_idx_o, vrf_wr_idx_o SHALL be 0; data_we_o=0.

Structure
REQ-029 State enum and default VlenWords/MaxOutstanding SHALL live in shared package vcve2_vlsu_pkg.
REQ-030 Outstanding counter SHALL be sub-module vcve2_outstanding_cnt (inc, dec, count, full, empty).
REQ-031 Address generation SHALL be an accumulator (add stride per grant), no multiplier.

Verification
REQ-032 Load vl=4, base=0x1000, stride=4, gnt immediate, rvalid 1 cycle later -> addrs 0x1000..0x100C, VRF writes idx 0..3, done_o 1 pulse.
REQ-033 Store vl=3, stride=-8 from base=0x4 -> addrs 0x4, 0xFFFFFFFC, 0xFFFFFFF4, we=1, wdata = VRF idx 0..2.
REQ-034 gnt always 1, rvalid delayed 5 cycles, MaxOutstanding=2 -> data_req_o drops with 2 outstanding, never 3.
REQ-035 vl=0 start -> done_o next cycle, data_req_o never asserted.
REQ-036 Load vl=2, data_err_i on element 1 -> err_o=1, only idx 0 written, done_o pulses; err_o clears on next start.
REQ-037 rst_ni low during DRAIN with 1 outstanding, late rvalid afterwards -> IDLE, no VRF write, counter stays 0.
